// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Holds the FSM state encoding and the hold-counter width function.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      FINISH = 2'd2
   } sweepState_e;

   // A one-cycle hold still needs a one-bit counter.
   function automatic int holdCntWidth(input int hold);
      return (hold <= 2) ? 1 : $clog2(hold);
   endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Hold timer: counts cycles a vector has been applied.
// The terminal-count flag marks the sampling cycle.
module tt_hold_timer #(
   parameter int HOLD = 10
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tc
);
   import tt_sweep_pkg::*;

   localparam int CW = holdCntWidth(HOLD);
   localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear has priority so a sampling cycle restarts the count at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_enable) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tc = i_enable && (cnt_q == LAST);

endmodule

// File: rtl/tt_sweep.sv
// Truth-table sweeper: walks every input vector, samples the DUT response
// after a hold time and compares it against an expected table.
module tt_sweep #(
   parameter int N_IN = 3,
   parameter int HOLD = 10,
   parameter logic [2**N_IN-1:0] EXPECTED = 8'b1001_0110
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic                i_y,
   output logic [N_IN-1:0]     o_vec,
   output logic                o_busy,
   output logic                o_done,
   output logic [2**N_IN-1:0]  o_result,
   output logic [N_IN:0]       o_err_cnt,
   output logic                o_pass,
   output logic [N_IN-1:0]     o_first_err
);
   import tt_sweep_pkg::*;

   localparam logic [N_IN-1:0] LAST_VEC = '1;

   sweepState_e         state_q;
   logic [N_IN-1:0]     vec_q;
   logic                busy_q;
   logic                done_q;
   logic [2**N_IN-1:0]  result_q;
   logic [N_IN:0]       errCnt_q;
   logic [N_IN:0]       errCnt_d;
   logic                pass_q;
   logic [N_IN-1:0]     firstErr_q;

   logic sampleTc;
   logic timerClear;
   logic timerEnable;
   logic mismatch;

   assign timerEnable = (state_q == SETTLE);
   assign timerClear  = (state_q != SETTLE) || i_abort || sampleTc;

   tt_hold_timer #(
      .HOLD (HOLD)
   ) u_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (timerClear),
      .i_enable (timerEnable),
      .o_tc     (sampleTc)
   );

   assign mismatch = (i_y != EXPECTED[vec_q]);
   assign errCnt_d = mismatch ? (errCnt_q + (N_IN+1)'(1)) : errCnt_q;

   // Abort beats both a start in IDLE and a sample in SETTLE.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         vec_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         errCnt_q   <= '0;
         pass_q     <= 1'b0;
         firstErr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (i_start && !i_abort) begin
                  state_q    <= SETTLE;
                  busy_q     <= 1'b1;
                  vec_q      <= '0;
                  result_q   <= '0;
                  errCnt_q   <= '0;
                  pass_q     <= 1'b0;
                  firstErr_q <= '0;
               end
            end
            SETTLE: begin
               if (i_abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  vec_q   <= '0;
               end else if (sampleTc) begin
                  result_q[vec_q] <= i_y;
                  errCnt_q        <= errCnt_d;
                  if (mismatch && (errCnt_q == '0)) begin
                     firstErr_q <= vec_q;
                  end
                  if (vec_q == LAST_VEC) begin
                     state_q <= FINISH;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (errCnt_d == '0);
                  end else begin
                     vec_q <= vec_q + N_IN'(1);
                  end
               end
            end
            FINISH: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               if (i_abort) begin
                  pass_q <= 1'b0;
                  vec_q  <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_vec       = vec_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_result    = result_q;
   assign o_err_cnt   = errCnt_q;
   assign o_pass      = pass_q;
   assign o_first_err = firstErr_q;

endmodule

// File: tb/tb_tt_sweep.sv
// Directed bench for tt_sweep: default 3-input sweep against an XOR3 model
// plus a 1-input, one-cycle-hold instance driven by a buffer model.
module tb_tt_sweep;

   logic clk = 1'b0;
   logic rstN;
   logic start;
   logic abort;
   logic stuck;
   logic y;
   logic [2:0] vec;
   logic busy;
   logic done;
   logic [7:0] result;
   logic [3:0] errCnt;
   logic pass;
   logic [2:0] firstErr;

   logic start1;
   logic y1;
   logic [0:0] vec1;
   logic busy1;
   logic done1;
   logic [1:0] result1;
   logic [1:0] errCnt1;
   logic pass1;
   logic [0:0] firstErr1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign y  = stuck ? 1'b0 : ^vec;
   assign y1 = vec1[0];

   tt_sweep #(
      .N_IN     (3),
      .HOLD     (10),
      .EXPECTED (8'b1001_0110)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_start     (start),
      .i_abort     (abort),
      .i_y         (y),
      .o_vec       (vec),
      .o_busy      (busy),
      .o_done      (done),
      .o_result    (result),
      .o_err_cnt   (errCnt),
      .o_pass      (pass),
      .o_first_err (firstErr)
   );

   tt_sweep #(
      .N_IN     (1),
      .HOLD     (1),
      .EXPECTED (2'b10)
   ) dut1 (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_start     (start1),
      .i_abort     (1'b0),
      .i_y         (y1),
      .o_vec       (vec1),
      .o_busy      (busy1),
      .o_done      (done1),
      .o_result    (result1),
      .o_err_cnt   (errCnt1),
      .o_pass      (pass1),
      .o_first_err (firstErr1)
   );

   // Advance one clock; everything is driven and sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Single-cycle start pulse; returns just after the accepting edge E0.
   task automatic applyStimulus();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int donePulses;

      rstN   = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      stuck  = 1'b0;
      start1 = 1'b0;
      #1;
      tick();
      tick();
      checkOutput("rst_vec", 32'(vec), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_result", 32'(result), 0);
      checkOutput("rst_errcnt", 32'(errCnt), 0);
      checkOutput("rst_pass", 32'(pass), 0);
      checkOutput("rst_firsterr", 32'(firstErr), 0);
      checkOutput("rst_busy1", 32'(busy1), 0);
      rstN = 1'b1;
      tick();

      $display("[TB] XOR3 sweep");
      applyStimulus();
      for (int c = 0; c < 80; c++) begin
         checkOutput("xor_vec", 32'(vec), 32'(c / 10));
         checkOutput("xor_busy", 32'(busy), 1);
         checkOutput("xor_done_early", 32'(done), 0);
         tick();
      end
      checkOutput("xor_done", 32'(done), 1);
      checkOutput("xor_busy_end", 32'(busy), 0);
      checkOutput("xor_vec_end", 32'(vec), 7);
      checkOutput("xor_result", 32'(result), 32'h96);
      checkOutput("xor_errcnt", 32'(errCnt), 0);
      checkOutput("xor_pass", 32'(pass), 1);
      tick();
      checkOutput("xor_done_clear", 32'(done), 0);
      checkOutput("xor_pass_hold", 32'(pass), 1);
      checkOutput("xor_result_hold", 32'(result), 32'h96);

      $display("[TB] stuck-at-0 sweep");
      stuck = 1'b1;
      applyStimulus();
      repeat (80) tick();
      checkOutput("sa0_done", 32'(done), 1);
      checkOutput("sa0_result", 32'(result), 0);
      checkOutput("sa0_errcnt", 32'(errCnt), 4);
      checkOutput("sa0_firsterr", 32'(firstErr), 1);
      checkOutput("sa0_pass", 32'(pass), 0);
      tick();
      stuck = 1'b0;

      $display("[TB] repeated start during sweep");
      applyStimulus();
      donePulses = 0;
      for (int c = 0; c < 80; c++) begin
         start = (c < 75) ? 1'(c % 2) : 1'b0;
         if (done) donePulses++;
         tick();
      end
      start = 1'b0;
      checkOutput("rep_no_early_done", 32'(donePulses), 0);
      checkOutput("rep_done", 32'(done), 1);
      checkOutput("rep_result", 32'(result), 32'h96);
      tick();
      checkOutput("rep_done_single", 32'(done), 0);
      checkOutput("rep_idle", 32'(busy), 0);

      start = 1'b1;
      abort = 1'b1;
      tick();
      checkOutput("startabort_busy", 32'(busy), 0);
      tick();
      checkOutput("startabort_busy2", 32'(busy), 0);
      start = 1'b0;
      abort = 1'b0;
      tick();

      $display("[TB] abort at vector 5");
      applyStimulus();
      repeat (55) tick();
      checkOutput("abt_vec_before", 32'(vec), 5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abt_busy", 32'(busy), 0);
      checkOutput("abt_vec", 32'(vec), 0);
      checkOutput("abt_pass", 32'(pass), 0);
      checkOutput("abt_result", 32'(result), 32'h16);
      checkOutput("abt_errcnt", 32'(errCnt), 0);
      donePulses = 0;
      for (int c = 0; c < 30; c++) begin
         if (done) donePulses++;
         tick();
      end
      checkOutput("abt_no_done", 32'(donePulses), 0);

      $display("[TB] reset mid-sweep then restart");
      applyStimulus();
      repeat (30) tick();
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      checkOutput("mrst_busy", 32'(busy), 0);
      checkOutput("mrst_vec", 32'(vec), 0);
      checkOutput("mrst_result", 32'(result), 0);
      tick();
      applyStimulus();
      repeat (80) tick();
      checkOutput("mrst_done", 32'(done), 1);
      checkOutput("mrst_result2", 32'(result), 32'h96);
      checkOutput("mrst_pass", 32'(pass), 1);
      tick();

      $display("[TB] N_IN=1 HOLD=1 sweep");
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      checkOutput("h1_busy0", 32'(busy1), 1);
      checkOutput("h1_vec0", 32'(vec1), 0);
      tick();
      checkOutput("h1_busy1", 32'(busy1), 1);
      checkOutput("h1_vec1", 32'(vec1), 1);
      checkOutput("h1_done_early", 32'(done1), 0);
      tick();
      checkOutput("h1_done", 32'(done1), 1);
      checkOutput("h1_busy_end", 32'(busy1), 0);
      checkOutput("h1_result", 32'(result1), 2);
      checkOutput("h1_errcnt", 32'(errCnt1), 0);
      checkOutput("h1_pass", 32'(pass1), 1);
      tick();
      checkOutput("h1_done_clear", 32'(done1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
